// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT control path: sizing constants
// and the sequencer state encoding seen by debug and neighbouring controllers.
package fft_pkg;

    localparam int LOG2N_DEFAULT  = 5;
    localparam int FFT_N          = 1 << LOG2N_DEFAULT;
    localparam int BFLY_PER_STAGE = FFT_N / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } fft_state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address map: (stage, k) -> upper/lower sample
// addresses and twiddle exponent for an in-place radix-2 DIT FFT.
module fft_addr_gen #(
    parameter int LOG2N = 5
) (
    input  logic [2:0]       stage,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx
);

    localparam logic [LOG2N-2:0] K_ONES     = '1;
    localparam logic [3:0]       LAST_STAGE = 4'(LOG2N - 1);

    logic [LOG2N-2:0] mask_s;
    logic [LOG2N-2:0] pos_s;
    logic [LOG2N-2:0] grp_s;
    logic [LOG2N-1:0] span_s;
    logic [3:0]       grp_shift_s;
    logic [3:0]       tw_shift_s;

    // mask_s is span-1; span never exceeds half the transform, so it fits k's width
    assign mask_s      = ~(K_ONES << stage);
    assign span_s      = {1'b0, mask_s} + (LOG2N)'(1);
    assign pos_s       = k & mask_s;
    assign grp_s       = k >> stage;
    assign grp_shift_s = {1'b0, stage} + 4'd1;
    assign tw_shift_s  = LAST_STAGE - {1'b0, stage};

    assign addr_a = ({1'b0, grp_s} << grp_shift_s) | {1'b0, pos_s};
    assign addr_b = addr_a + span_s;
    assign tw_idx = pos_s << tw_shift_s;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Handshaked stage/butterfly scheduler for the in-place radix-2 FFT: issues one
// butterfly at a time and advances only when the datapath acknowledges it.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic             bfly_done,
    output logic             busy,
    output logic             done,
    output logic             bfly_start,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic [2:0]       stage_count,
    output logic [LOG2N-2:0] bfly_count,
    output logic             stage_strobe
);

    localparam logic [LOG2N-2:0] LAST_K     = '1;
    localparam logic [LOG2N-2:0] K_ONE      = (LOG2N-1)'(1);
    localparam logic [2:0]       LAST_STAGE = 3'(LOG2N - 1);

    fft_state_e       state_r;
    fft_state_e       state_nxt_s;

    logic [2:0]       stage_r;
    logic [LOG2N-2:0] k_r;
    logic             busy_r;
    logic             done_r;
    logic             bfly_start_r;
    logic             strobe_r;
    logic [LOG2N-1:0] addr_a_r;
    logic [LOG2N-1:0] addr_b_r;
    logic [LOG2N-2:0] tw_r;

    logic [2:0]       stage_nxt_s;
    logic [LOG2N-2:0] k_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             bfly_start_nxt_s;
    logic             strobe_nxt_s;
    logic             load_addr_s;

    logic [LOG2N-1:0] gen_a_s;
    logic [LOG2N-1:0] gen_b_s;
    logic [LOG2N-2:0] gen_tw_s;

    // Addresses are generated from the next (stage, k) so they are valid with bfly_start
    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage  (stage_nxt_s),
        .k      (k_nxt_s),
        .addr_a (gen_a_s),
        .addr_b (gen_b_s),
        .tw_idx (gen_tw_s)
    );

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (!bfly_done) begin
                    state_nxt_s = WAIT;
                end else if ((k_r == LAST_K) && (stage_r == LAST_STAGE)) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output and counter next values, registered below
    always_comb begin
        stage_nxt_s      = stage_r;
        k_nxt_s          = k_r;
        busy_nxt_s       = busy_r;
        done_nxt_s       = 1'b0;
        bfly_start_nxt_s = 1'b0;
        strobe_nxt_s     = 1'b0;
        load_addr_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    stage_nxt_s      = 3'd0;
                    k_nxt_s          = '0;
                    busy_nxt_s       = 1'b1;
                    bfly_start_nxt_s = 1'b1;
                    load_addr_s      = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ISSUE: begin
                busy_nxt_s = 1'b1;
            end
            WAIT: begin
                if (!bfly_done) begin
                    busy_nxt_s = 1'b1;
                end else if (k_r != LAST_K) begin
                    k_nxt_s          = k_r + K_ONE;
                    bfly_start_nxt_s = 1'b1;
                    load_addr_s      = 1'b1;
                end else if (stage_r != LAST_STAGE) begin
                    stage_nxt_s      = stage_r + 3'd1;
                    k_nxt_s          = '0;
                    strobe_nxt_s     = 1'b1;
                    bfly_start_nxt_s = 1'b1;
                    load_addr_s      = 1'b1;
                end else begin
                    strobe_nxt_s = 1'b1;
                end
            end
            FINISH: begin
                stage_nxt_s = 3'd0;
                k_nxt_s     = '0;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b1;
            end
            default: begin
                stage_nxt_s = 3'd0;
                k_nxt_s     = '0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Output and counter registers; addresses only move on ISSUE entry
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stage_r      <= 3'd0;
            k_r          <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            bfly_start_r <= 1'b0;
            strobe_r     <= 1'b0;
            addr_a_r     <= '0;
            addr_b_r     <= '0;
            tw_r         <= '0;
        end else begin
            stage_r      <= stage_nxt_s;
            k_r          <= k_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            bfly_start_r <= bfly_start_nxt_s;
            strobe_r     <= strobe_nxt_s;
            if (load_addr_s) begin
                addr_a_r <= gen_a_s;
                addr_b_r <= gen_b_s;
                tw_r     <= gen_tw_s;
            end else begin
                addr_a_r <= addr_a_r;
                addr_b_r <= addr_b_r;
                tw_r     <= tw_r;
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign bfly_start   = bfly_start_r;
    assign stage_strobe = strobe_r;
    assign addr_a       = addr_a_r;
    assign addr_b       = addr_b_r;
    assign tw_idx       = tw_r;
    assign stage_count  = stage_r;
    assign bfly_count   = k_r;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: acts as the butterfly unit with random
// acknowledge latency and compares the issued schedule against a reference.
module tb_fft_stage_sequencer;

    localparam int LOG2N = 5;
    localparam int NB    = 1 << (LOG2N - 1);
    localparam int NS    = LOG2N;
    localparam int TOTAL = NS * NB;

    logic             clk = 1'b0;
    logic             n_reset;
    logic             start;
    logic             bfly_done;
    logic             busy;
    logic             done;
    logic             bfly_start;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic [2:0]       stage_count;
    logic [LOG2N-2:0] bfly_count;
    logic             stage_strobe;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference schedule: stage-major, butterfly-minor
    int ea [TOTAL];
    int eb [TOTAL];
    int et [TOTAL];
    int es [TOTAL];
    int ek [TOTAL];

    fft_stage_sequencer #(.LOG2N(LOG2N)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .start        (start),
        .bfly_done    (bfly_done),
        .busy         (busy),
        .done         (done),
        .bfly_start   (bfly_start),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .tw_idx       (tw_idx),
        .stage_count  (stage_count),
        .bfly_count   (bfly_count),
        .stage_strobe (stage_strobe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic build_model();
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < NB; k++) begin
                int idx, span, pos, grp;
                idx  = s * NB + k;
                span = 1 << s;
                pos  = k % span;
                grp  = k / span;
                ea[idx] = grp * 2 * span + pos;
                eb[idx] = ea[idx] + span;
                et[idx] = pos * (NB / span);
                es[idx] = s;
                ek[idx] = k;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_bstart"}, bfly_start, 0);
        check_val({tag, "_strobe"}, stage_strobe, 0);
        check_val({tag, "_addr"}, {addr_a, addr_b, tw_idx}, 0);
        check_val({tag, "_cnt"}, {stage_count, bfly_count}, 0);
    endtask

    // One transform; the bench plays the butterfly unit
    task automatic run_transform(input int max_lat, input bit chaos, input bit do_abort, input bit timing_chk);
        int idx = 0, lat = 1, j = 0, strobes = 0, guard = 0;
        int first_bs = 0, last_done = 0;
        bit out_s = 0, exp_bs = 1, exp_ss = 0, exp_fin = 0, exp_done = 0, finished = 0, aborted = 0;
        bit nexp_bs, nexp_ss, nexp_fin, nexp_done;
        logic [LOG2N-1:0] la = '0, lb = '0;
        logic [LOG2N-2:0] lt = '0;

        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        while (!finished && guard < 3000) begin
            start     = 1'b0;
            bfly_done = 1'b0;
            nexp_bs = 0; nexp_ss = 0; nexp_fin = 0; nexp_done = 0;
            check_val("bfly_start", bfly_start, exp_bs);
            check_val("stage_strobe", stage_strobe, exp_ss);
            check_val("done", done, exp_done);
            if (stage_strobe) strobes++;
            if (exp_done) begin
                check_val("busy_at_done", busy, 0);
                check_val("counts_clear", {stage_count, bfly_count}, 0);
                check_val("strobe_total", strobes, NS);
                if (timing_chk) begin
                    check_val("bfly_window", last_done - first_bs, 2 * TOTAL - 1);
                    check_val("run_len", cyc - first_bs, 2 * TOTAL + 1);
                end
                finished = 1;
            end else if (exp_fin) begin
                check_val("busy_in_finish", busy, 1);
                nexp_done = 1;
            end else if (exp_bs) begin
                check_val("addr_a", addr_a, ea[idx]);
                check_val("addr_b", addr_b, eb[idx]);
                check_val("tw_idx", tw_idx, et[idx]);
                check_val("stage_count", stage_count, es[idx]);
                check_val("bfly_count", bfly_count, ek[idx]);
                if (es[idx] == 0 && ek[idx] < 3)
                    check_val("first_issues", {addr_a, addr_b, tw_idx}, {5'(2 * ek[idx]), 5'(2 * ek[idx] + 1), 4'd0});
                if (es[idx] == 2 && ek[idx] == 5)
                    check_val("spot_s2k5", {addr_a, addr_b, tw_idx}, {5'd9, 5'd13, 4'd4});
                if (es[idx] == 2 && ek[idx] == 7)
                    check_val("spot_s2k7", {addr_a, addr_b, tw_idx}, {5'd11, 5'd15, 4'd12});
                if (es[idx] == 4)
                    check_val("stage4_issue", {addr_a, addr_b, tw_idx}, {5'(ek[idx]), 5'(ek[idx] + 16), 4'(ek[idx])});
                if (idx == 0) first_bs = cyc;
                la = addr_a; lb = addr_b; lt = tw_idx;
                lat = (max_lat <= 1) ? 1 : int'($urandom_range(1, max_lat));
                j = 0;
                out_s = 1;
                if (chaos) begin
                    bfly_done = 1'($urandom_range(0, 1));
                    start     = 1'($urandom_range(0, 1));
                end
                if (do_abort && es[idx] == 3 && ek[idx] == 6) begin
                    bfly_done = 1'b0;
                    tick();
                    #2;
                    n_reset = 1'b0;
                    #1;
                    check_all_zero("async_reset");
                    bfly_done = 1'b1;
                    @(negedge clk);
                    n_reset = 1'b1;
                    tick();
                    tick();
                    check_val("pending_done_ignored", bfly_start, 0);
                    check_val("idle_after_reset", busy, 0);
                    bfly_done = 1'b0;
                    aborted   = 1;
                    finished  = 1;
                end
                idx++;
            end else if (out_s) begin
                j++;
                check_val("hold_addr", {addr_a, addr_b, tw_idx}, {la, lb, lt});
                check_val("busy_in_wait", busy, 1);
                if (chaos) start = 1'($urandom_range(0, 1));
                if (j == lat) begin
                    bfly_done = 1'b1;
                    out_s     = 0;
                    last_done = cyc;
                    nexp_ss   = (ek[idx-1] == NB - 1);
                    if (idx == TOTAL) nexp_fin = 1;
                    else              nexp_bs  = 1;
                end
            end
            if (!finished) begin
                exp_bs = nexp_bs; exp_ss = nexp_ss; exp_fin = nexp_fin; exp_done = nexp_done;
                tick();
                guard++;
            end
        end
        start     = 1'b0;
        bfly_done = 1'b0;
        if (!finished) check_val("timeout", 0, 1);
        if (!aborted) tick();
    endtask

    initial begin
        n_reset   = 1'b0;
        start     = 1'b0;
        bfly_done = 1'b0;
        build_model();
        repeat (3) tick();
        check_all_zero("in_reset");
        n_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bfly_done = 1'(i % 2);
            tick();
            check_val("idle_no_bstart", bfly_start, 0);
            check_val("idle_busy", busy, 0);
        end
        bfly_done = 1'b0;
        tick();
        check_all_zero("idle");

        run_transform(1, 0, 0, 1);
        run_transform(8, 1, 0, 0);
        run_transform(8, 1, 0, 0);
        run_transform(4, 1, 1, 0);
        run_transform(1, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
